// File: rtl/miriscv_data_mem_responder.sv
// Word-organised data memory that answers every request after a fixed
// LATENCY-deep response pipeline; out-of-range accesses respond with err.
module miriscv_data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem [DEPTH];
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        wr_en_c;
  resp_t       head_c;
  resp_t       pipe_q [LATENCY];

  // Unsigned offset from the base: anything at or beyond DEPTH words is out of range,
  // including addresses below BASE_ADDR, which wrap to large offsets.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign idx      = offset[AW+1:2];
  assign wr_en_c  = req_i & we_i & in_range & ~arst_i;

  // Response entering the pipeline for the request seen at this edge.
  always_comb begin
    head_c = '0;
    if (req_i) begin
      head_c.valid = 1'b1;
      head_c.err   = ~in_range;
      if (!we_i && in_range) begin
        head_c.data = mem[idx];
      end
    end
  end

  // Byte-masked write port; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response shift pipeline; reset flushes everything in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= head_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rvalid_o = pipe_q[LATENCY-1].valid;
  assign err_o    = pipe_q[LATENCY-1].err;
  assign rdata_o  = pipe_q[LATENCY-1].data;

endmodule

// File: tb/tb_miriscv_data_mem_responder.sv
// Bench for miriscv_data_mem_responder: four instances of differing latency and
// address window share one stimulus stream and are checked against a word-array model.
module tb_miriscv_data_mem_responder;

  localparam int NDUT = 4;

  typedef struct {
    bit          v;
    bit          e;
    logic [31:0] d;
  } rsp_t;

  logic        clk = 1'b0;
  logic        arst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rv [NDUT];
  logic [31:0] rd [NDUT];
  logic        er [NDUT];

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int first_valid = 0;
  int lat_of [NDUT] = '{1, 3, 4, 2};
  bit uses_b [NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Model state: window A is 1024 words at 0x0, window B is 16 words at 0x100.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [16];
  rsp_t        hist_a [$];
  rsp_t        hist_b [$];

  always #5 clk = ~clk;

  miriscv_data_mem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_l1 (
    .clk_i(clk), .arst_i(arst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rv[0]), .rdata_o(rd[0]), .err_o(er[0]));
  miriscv_data_mem_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u_l3 (
    .clk_i(clk), .arst_i(arst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rv[1]), .rdata_o(rd[1]), .err_o(er[1]));
  miriscv_data_mem_responder #(.DEPTH(1024), .LATENCY(4), .BASE_ADDR(32'h0000_0000)) u_l4 (
    .clk_i(clk), .arst_i(arst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rv[2]), .rdata_o(rd[2]), .err_o(er[2]));
  miriscv_data_mem_responder #(.DEPTH(16), .LATENCY(2), .BASE_ADDR(32'h0000_0100)) u_b (
    .clk_i(clk), .arst_i(arst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rv[3]), .rdata_o(rd[3]), .err_o(er[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a, input longint base, input longint depth);
    longint la;
    la = longint'({32'd0, a});
    return (la >= base) && (la < base + depth * 4);
  endfunction

  // Compute the response the current inputs earn at the coming edge, and apply writes.
  task automatic model_step();
    rsp_t ra;
    rsp_t rb;
    int   wi;
    ra = '{v: 1'b0, e: 1'b0, d: 32'h0};
    rb = '{v: 1'b0, e: 1'b0, d: 32'h0};
    if (!arst && req) begin
      ra.v = 1'b1;
      ra.e = !in_rng(addr, 0, 1024);
      if (!ra.e) begin
        wi = int'(addr >> 2);
        if (we) begin
          for (int k = 0; k < 4; k++) if (be[k]) mem_a[wi][8*k +: 8] = wdata[8*k +: 8];
        end else begin
          ra.d = mem_a[wi];
        end
      end
      rb.v = 1'b1;
      rb.e = !in_rng(addr, 32'h100, 16);
      if (!rb.e) begin
        wi = int'((addr - 32'h100) >> 2);
        if (we) begin
          for (int k = 0; k < 4; k++) if (be[k]) mem_b[wi][8*k +: 8] = wdata[8*k +: 8];
        end else begin
          rb.d = mem_b[wi];
        end
      end
    end
    hist_a.push_back(ra);
    hist_b.push_back(rb);
  endtask

  // After n edges, a latency-L instance presents the response of edge n-L.
  function automatic rsp_t exp_at(input int k);
    rsp_t r;
    int   i;
    r = '{v: 1'b0, e: 1'b0, d: 32'h0};
    i = n - lat_of[k];
    if (i >= 0 && i >= first_valid) r = uses_b[k] ? hist_b[i] : hist_a[i];
    return r;
  endfunction

  task automatic check_all();
    rsp_t e;
    for (int k = 0; k < NDUT; k++) begin
      e = exp_at(k);
      chk($sformatf("rvalid[%0d]@%0d", k, n), 32'(rv[k]), 32'(e.v));
      chk($sformatf("err[%0d]@%0d", k, n), 32'(er[k]), 32'(e.e));
      chk($sformatf("rdata[%0d]@%0d", k, n), rd[k], e.d);
    end
  endtask

  task automatic cycle(input logic rq, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd);
    req = rq; we = w; be = b; addr = a; wdata = wd;
    model_step();
    @(posedge clk);
    n++;
    #1;
    check_all();
  endtask

  task automatic idle(input int cnt);
    for (int c = 0; c < cnt; c++) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 4)      return 32'h100 + 32'($urandom_range(0, 63));
    else if (sel < 7) return 32'($urandom_range(0, 32'hFFF));
    else if (sel < 9) return 32'hFF0 + 32'($urandom_range(0, 32'h120));
    else              return $urandom();
  endfunction

  initial begin
    arst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    #1;
    check_all();
    idle(2);
    arst = 1'b0;

    // Fill every word so later reads have defined contents in both windows.
    for (int w = 0; w < 1024; w++) cycle(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom());

    // Write then read on consecutive edges.
    cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hA5A5_1234);
    chk("wr_rvalid", 32'(rv[0]), 32'h1);
    cycle(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    chk("rd_rvalid", 32'(rv[0]), 32'h1);
    chk("rd_data", rd[0], 32'hA5A5_1234);
    chk("rd_err", 32'(er[0]), 32'h0);

    // Low address bits are ignored.
    cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D);
    cycle(1'b1, 1'b0, 4'h0, 32'h13, 32'h0);
    chk("unaligned_rd", rd[0], 32'hCAFE_F00D);

    // Partial byte-enable write.
    cycle(1'b1, 1'b1, 4'hF, 32'h20, 32'h1122_3344);
    cycle(1'b1, 1'b1, 4'b0101, 32'h20, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    chk("be_merge", rd[0], 32'h11FF_33FF);

    // One past the top of the window, read and write.
    cycle(1'b1, 1'b1, 4'hF, 32'h0, 32'h0BAD_C0DE);
    cycle(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
    chk("oor_rd_err", 32'(er[0]), 32'h1);
    chk("oor_rd_data", rd[0], 32'h0);
    cycle(1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF);
    chk("oor_wr_err", 32'(er[0]), 32'h1);
    cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("word0_kept", rd[0], 32'h0BAD_C0DE);

    // Eight back-to-back reads through the deeper pipelines.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 4'hF, 32'(32'h40 + i * 4), $urandom());
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'h0, 32'(32'h40 + i * 4), 32'h0);
    idle(5);

    // Reset pulse between edges with two reads in flight.
    cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    cycle(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    req = 1'b0;
    #2 arst = 1'b1;
    first_valid = n;
    #1;
    chk("rst_l1_rvalid", 32'(rv[0]), 32'h0);
    chk("rst_l4_rvalid", 32'(rv[2]), 32'h0);
    check_all();
    #1 arst = 1'b0;
    idle(6);

    // Writes while reset is held are dropped; first edge after release is served.
    #2 arst = 1'b1;
    first_valid = n;
    cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
    arst = 1'b0;
    cycle(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    chk("post_rst_rvalid", 32'(rv[0]), 32'h1);
    chk("post_rst_data", rd[0], 32'hCAFE_F00D);

    // Randomised traffic with one asynchronous reset mid-stream.
    for (int it = 0; it < 1500; it++) begin
      if (it == 700) begin
        #2 arst = 1'b1;
        first_valid = n;
        #1 arst = 1'b0;
      end
      cycle(1'b1 && ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
            4'($urandom()), pick_addr(), $urandom());
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miriscv_data_mem_responder.md
MIRISCV_DATA_MEM_RESPONDER -- requirements
Module: miriscv_data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024; memory size in 32-bit words, power of two, 2..65536.
REQ-002 SHALL have parameter LATENCY, default 1; request-to-response cycles, legal range 1..4.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000; byte address of word 0, DEPTH*4-aligned.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port arst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_i  input  1  request valid; accepted unconditionally every cycle it is high.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port be_i  input  4  byte enables for writes; be_i[k] selects wdata_i[8k+7:8k].
REQ-009 SHALL have port addr_i  input  32  byte address.
REQ-010 SHALL have port wdata_i  input  32  write data.
REQ-011 SHALL have port rvalid_o  output  1  response valid, one pulse per accepted request.
REQ-012 SHALL have port rdata_o  output  32  read data, valid while rvalid_o is high.
REQ-013 SHALL have port err_o  output  1  out-of-range flag, qualified by rvalid_o.

Function
REQ-014 SHALL accept a request on every rising edge where req_i=1; there is no grant or backpressure.
REQ-015 SHALL form word index = (addr_i - BASE_ADDR) >> 2; addr_i[1:0] ignored, no misalignment error.
REQ-016 SHALL treat a request as in range iff BASE_ADDR <= addr_i < BASE_ADDR + DEPTH*4.
REQ-017 SHALL, for an in-range write, update at the accepting edge exactly the bytes with be_i=1; other bytes retain their value; be_i=0000 writes nothing but still responds.
REQ-018 SHALL, for an in-range read, capture the full word at the accepting edge; the read reflects every write accepted on earlier edges.
REQ-019 SHALL ignore out-of-range writes (no array change), and SHALL return rdata 0 for out-of-range reads.
REQ-020 SHALL carry each accepted request through a LATENCY-deep shift pipeline of {valid, err, data}; a request accepted at edge N drives rvalid_o=1 in the cycle after edge N+LATENCY-1 (LATENCY=1: the cycle following acceptance).
REQ-021 SHALL keep responses strictly in order, one per accepted request, with back-to-back requests producing back-to-back rvalid_o pulses and no bubbles.
REQ-022 SHALL drive rdata_o=0 for write responses and whenever rvalid_o=0.
REQ-023 SHALL drive err_o=1 with rvalid_o for out-of-range requests and err_o=0 otherwise; err_o=0 whenever rvalid_o=0.
REQ-024 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-025 SHALL leave unknown memory contents unchanged after reset; memory has no reset or initialisation.

Reset
REQ-026 SHALL, while arst_i=1, force rvalid_o=0, rdata_o=0, err_o=0 and clear all pipeline valid bits asynchronously.
REQ-027 SHALL discard all in-flight responses when reset asserts mid-operation; no response for them appears after deassertion.
REQ-028 SHALL ignore req_i while arst_i=1, including writes; the array is unchanged.
REQ-029 SHALL accept requests from the first rising edge after arst_i deasserts.

Verification
REQ-030 SHALL cover: LATENCY=1, write 0xA5A5_1234 to 0x10 with be=1111, then read 0x10 on the next edge -> rvalid_o high in both following cycles; second response rdata_o=0xA5A5_1234, err_o=0.
REQ-031 SHALL cover: word 0x20 = 0x1122_3344; write 0xFFFF_FFFF with be=0101; read -> 0x11FF_33FF.
REQ-032 SHALL cover: LATENCY=3, 8 back-to-back reads of 8 preloaded words -> 8 consecutive rvalid_o pulses starting 3 cycles after the first request, data in request order.
REQ-033 SHALL cover: DEPTH=1024, BASE_ADDR=0, read from 0x0000_1000 and write to 0x0000_1000 -> err_o=1, rdata_o=0; word 0 unchanged on read-back.
REQ-034 SHALL cover: LATENCY=4, 2 reads in flight, then arst_i pulsed asynchronously between edges -> outputs 0 immediately; no rvalid_o pulse after release.
REQ-035 SHALL cover: read address 0x0000_0013 after writing 0xCAFE_F00D to 0x10 -> rdata_o=0xCAFE_F00D.
